// File: rtl/nativephy_lock_monitor.sv
// nativephy_lock_monitor
//   Per-channel lock qualifier for the NativePHY transceiver bank.
//   Each channel synchronises pll_locked and rx_is_lockedtoref, debounces
//   their AND and reports a filtered lock flag. A loss of an established
//   lock sets a sticky flag, bumps a saturating counter and can raise a
//   maskable level interrupt. Status and control sit on an Avalon-MM CSR
//   slave with 1-cycle registered read data.
// Ports
//   clk, reset_n          single clock, async active-low reset
//   csr_address/read/write/writedata/readdata   CSR slave
//   pll_locked, rx_is_lockedtoref   async PHY status, one bit per channel
//   locked_filtered       qualified lock per channel
//   lol_irq               level interrupt, OR of (sticky & mask)

// Per-channel slice: synchroniser, debounce FSM, sticky flag, LOL counter.
module nativephy_lock_monitor_ch #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pll_i,
  input  logic                 lockref_i,
  input  logic                 w1c_i,
  input  logic                 cnt_clr_i,
  output logic                 pll_s_o,
  output logic                 lockref_s_o,
  output logic                 locked_o,
  output logic                 sticky_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  localparam int QW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [QW-1:0]        QMAX = QW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  typedef enum logic [1:0] {UNLOCKED, QUALIFY, LOCKED} state_e;

  logic [1:0]           pll_sync_q, lref_sync_q;
  logic                 raw;
  state_e               state_q, state_d;
  logic [QW-1:0]        qcnt_q, qcnt_d;
  logic                 locked_q;
  logic                 sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lol;

  assign raw = pll_sync_q[1] & lref_sync_q[1];

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    lol     = 1'b0;
    case (state_q)
      UNLOCKED: if (raw) begin
        state_d = QUALIFY;
        qcnt_d  = '0;
      end
      QUALIFY: begin
        if (!raw)               state_d = UNLOCKED;
        else if (qcnt_q == QMAX) state_d = LOCKED;
        else                    qcnt_d  = qcnt_q + 1'b1;
      end
      LOCKED: if (!raw) begin
        state_d = UNLOCKED;
        lol     = 1'b1;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // New LOL beats a same-cycle W1C; a counter clear coincident with an LOL
  // leaves the counter at 1.
  always_comb begin
    sticky_d = (sticky_q & ~w1c_i) | lol;
    cnt_d    = cnt_clr_i ? '0 : cnt_q;
    if (lol && cnt_d != CMAX) cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_sync_q  <= '0;
      lref_sync_q <= '0;
      state_q     <= UNLOCKED;
      qcnt_q      <= '0;
      locked_q    <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      pll_sync_q  <= {pll_sync_q[0], pll_i};
      lref_sync_q <= {lref_sync_q[0], lockref_i};
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      // Tracks the next state so the flag moves on the same edge as the FSM.
      locked_q    <= (state_d == LOCKED);
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pll_s_o     = pll_sync_q[1];
  assign lockref_s_o = lref_sync_q[1];
  assign locked_o    = locked_q;
  assign sticky_o    = sticky_q;
  assign cnt_o       = cnt_q;
endmodule

module nativephy_lock_monitor #(
  parameter int NUM_OF_CH       = 1,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           csr_address,
  input  logic                 csr_read,
  input  logic                 csr_write,
  input  logic [31:0]          csr_writedata,
  output logic [31:0]          csr_readdata,
  input  logic [NUM_OF_CH-1:0] pll_locked,
  input  logic [NUM_OF_CH-1:0] rx_is_lockedtoref,
  output logic [NUM_OF_CH-1:0] locked_filtered,
  output logic                 lol_irq
);
  logic [NUM_OF_CH-1:0]                pll_s, lref_s, sticky, w1c;
  logic [NUM_OF_CH-1:0][CNT_WIDTH-1:0] cnt;
  logic                                cnt_clr;
  logic [NUM_OF_CH-1:0]                mask_q, mask_d;
  logic [3:0]                          sel_q, sel_d;
  logic [31:0]                         rdata_q, rdata_d;
  logic                                irq_q;
  logic                                unused_wdata;

  assign unused_wdata = ^csr_writedata;

  assign w1c     = (csr_write && csr_address == 4'd1) ? csr_writedata[NUM_OF_CH-1:0] : '0;
  assign cnt_clr = csr_write && csr_address == 4'd6 && csr_writedata[0];

  for (genvar g = 0; g < NUM_OF_CH; g++) begin : g_ch
    nativephy_lock_monitor_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .pll_i      (pll_locked[g]),
      .lockref_i  (rx_is_lockedtoref[g]),
      .w1c_i      (w1c[g]),
      .cnt_clr_i  (cnt_clr),
      .pll_s_o    (pll_s[g]),
      .lockref_s_o(lref_s[g]),
      .locked_o   (locked_filtered[g]),
      .sticky_o   (sticky[g]),
      .cnt_o      (cnt[g])
    );
  end

  always_comb begin
    mask_d = mask_q;
    sel_d  = sel_q;
    if (csr_write && csr_address == 4'd2) mask_d = csr_writedata[NUM_OF_CH-1:0];
    if (csr_write && csr_address == 4'd3) sel_d  = csr_writedata[3:0];
  end

  // Reads see the registered state, so a same-cycle write is not visible.
  always_comb begin
    rdata_d = rdata_q;
    if (csr_read) begin
      rdata_d = '0;
      case (csr_address)
        4'd0: rdata_d[NUM_OF_CH-1:0] = locked_filtered;
        4'd1: rdata_d[NUM_OF_CH-1:0] = sticky;
        4'd2: rdata_d[NUM_OF_CH-1:0] = mask_q;
        4'd3: rdata_d[3:0]           = sel_q;
        4'd4: begin
          // Out-of-range selects fall through with zero.
          for (int i = 0; i < NUM_OF_CH; i++)
            if (sel_q == 4'(i)) rdata_d[CNT_WIDTH-1:0] = cnt[i];
        end
        4'd5: begin
          rdata_d[NUM_OF_CH-1:0]    = pll_s;
          rdata_d[16 +: NUM_OF_CH]  = lref_s;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      irq_q   <= |(sticky & mask_q);
    end
  end

  assign csr_readdata = rdata_q;
  assign lol_irq      = irq_q;
endmodule

// File: tb/tb_nativephy_lock_monitor.sv
// Directed bench for nativephy_lock_monitor: 2 channels, 16-cycle debounce,
// 2-bit counters. Inputs change 1 time unit after a rising edge and outputs
// are sampled there, so "tick" counts edges since the last stimulus change.
module tb_nativephy_lock_monitor;
  localparam int N = 2;
  localparam int D = 16;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   csr_address;
  logic         csr_read, csr_write;
  logic [31:0]  csr_writedata, csr_readdata;
  logic [N-1:0] pll, rx, lf;
  logic         irq;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  nativephy_lock_monitor #(.NUM_OF_CH(N), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .csr_address      (csr_address),
    .csr_read         (csr_read),
    .csr_write        (csr_write),
    .csr_writedata    (csr_writedata),
    .csr_readdata     (csr_readdata),
    .pll_locked       (pll),
    .rx_is_lockedtoref(rx),
    .locked_filtered  (lf),
    .lol_irq          (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    csr_address = a; csr_read = 1'b1;
    tick();
    csr_read = 1'b0;
    chk(tag, csr_readdata, exp);
  endtask

  task automatic lock_drop0();
    pll[0] = 1'b1;
    repeat (20) tick();
    pll[0] = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset_n = 1'b0; pll = '0; rx = '0;
    csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    #1;
    chk("rst_lf", 32'(lf), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", csr_readdata, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    chk_rd("rst_mask", 4'd2, 32'h0);
    chk_rd("rst_sel", 4'd3, 32'h0);
    chk_rd("rst_cnt", 4'd4, 32'h0);

    // Plain qualify on ch0: rises after D+3 edges from the stimulus change.
    pll = 2'b01; rx = 2'b01;
    repeat (18) tick();
    chk("q0_early", 32'(lf), 32'h0);
    tick();
    chk("q0_rise", 32'(lf), 32'h1);
    chk_rd("q0_addr0", 4'd0, 32'h1);

    // One-cycle CDR glitch on ch1 mid-qualify restarts the debounce.
    pll = 2'b11; rx = 2'b11;
    repeat (9) tick();
    rx[1] = 1'b0;
    tick();
    rx[1] = 1'b1;
    repeat (18) tick();
    chk("gl_early", 32'(lf), 32'h1);
    tick();
    chk("gl_rise", 32'(lf), 32'h3);
    chk_rd("gl_sticky", 4'd1, 32'h0);
    wr(4'd3, 32'h1);
    chk_rd("gl_cnt1", 4'd4, 32'h0);
    wr(4'd3, 32'h0);

    // LOL on ch1, irq mask/unmask path.
    pll[1] = 1'b0;
    repeat (2) tick();
    chk("lol1_hold", 32'(lf), 32'h3);
    tick();
    chk("lol1_fall", 32'(lf), 32'h1);
    chk_rd("lol1_sticky", 4'd1, 32'h2);
    wr(4'd2, 32'hFFFF_FFFE);
    chk("irq_lag", 32'(irq), 32'h0);
    tick();
    chk("irq_set", 32'(irq), 32'h1);
    chk_rd("mask_rb", 4'd2, 32'h2);
    wr(4'd1, 32'h2);
    chk("irq_w1c_lag", 32'(irq), 32'h1);
    tick();
    chk("irq_clr", 32'(irq), 32'h0);
    chk_rd("w1c_sticky", 4'd1, 32'h0);
    wr(4'd3, 32'h1);
    chk_rd("cnt1", 4'd4, 32'h1);
    wr(4'd3, 32'h5);
    chk_rd("sel_oor", 4'd3, 32'h5);
    chk_rd("cnt_oor", 4'd4, 32'h0);
    wr(4'd3, 32'h0);
    chk_rd("raw_status", 4'd5, 32'h0003_0001);
    tick();
    chk("rdata_hold", csr_readdata, 32'h0003_0001);
    chk_rd("addr7", 4'd7, 32'h0);
    chk_rd("addr6", 4'd6, 32'h0);

    // W1C coincident with a new LOL on ch0: set wins.
    pll[0] = 1'b0;
    repeat (2) tick();
    wr(4'd1, 32'h1);
    chk("w1c_lol_fall", 32'(lf), 32'h0);
    chk_rd("w1c_lol_sticky", 4'd1, 32'h1);
    chk_rd("w1c_lol_cnt", 4'd4, 32'h1);

    // Counter saturation and clear.
    wr(4'd6, 32'h1);
    chk_rd("cnt_clr0", 4'd4, 32'h0);
    for (int i = 0; i < 5; i++) lock_drop0();
    chk_rd("cnt_sat", 4'd4, 32'h3);
    wr(4'd6, 32'h1);
    chk_rd("cnt_clr1", 4'd4, 32'h0);
    pll[0] = 1'b1;
    repeat (20) tick();
    chk("relock", 32'(lf), 32'h1);
    pll[0] = 1'b0;
    repeat (2) tick();
    wr(4'd6, 32'h1);
    chk_rd("clr_lol", 4'd4, 32'h1);

    // Reset while locked with irq asserted.
    pll[0] = 1'b1;
    repeat (20) tick();
    wr(4'd2, 32'h1);
    repeat (2) tick();
    chk("pre_rst_irq", 32'(irq), 32'h1);
    chk_rd("pre_rst_lf", 4'd0, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_lf", 32'(lf), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_rdata", csr_readdata, 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (21) tick();
    chk("post_rst_lock", 32'(lf), 32'h1);
    chk_rd("post_rst_sticky", 4'd1, 32'h0);
    chk_rd("post_rst_cnt", 4'd4, 32'h0);
    chk_rd("post_rst_mask", 4'd2, 32'h0);
    chk("post_rst_irq", 32'(irq), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
